multicycle_control: RTL and testbench
=====================================

# multicycle_control

Main control unit for the multicycle ARM-subset CPU. It sequences the shared datapath (single memory, ALU, register file, PC) one instruction at a time through a Moore state machine, and decodes data-processing, memory and branch instructions. It holds the NZCV flags and gates every architectural write with the instruction's condition field. It sits between the instruction register and the datapath mux selects and write enables.

## Interface
- No parameters.
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- Instr  in  20  IR bits [31:12]: Cond[31:28], Op[27:26], Funct[25:20], Rd[15:12]
- ALUFlags  in  4  ALU result flags {N,Z,C,V}
- PCWrite, IRWrite, RegWrite, MemWrite  out  1 each  datapath write enables
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALU result register
- RegSrc  out  2  [0] = (Op==10), [1] = (Op==01)
- ImmSrc  out  2  equals Op
- ALUSrcA  out  1  0 = register A, 1 = PC
- ALUSrcB  out  2  00 = register B, 01 = extended immediate, 10 = constant 4
- ResultSrc  out  2  00 = ALUOut, 01 = memory data, 10 = ALU direct
- ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- State  out  4  current state encoding, for debug

## Operation
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9. Encodings 10–15 are illegal and return to FETCH on the next edge.
- State transitions:
  - FETCH → DECODE.
  - DECODE: Op=01 → MEMADR; Op=00 with Funct[5]=0 → EXECR; Op=00 with Funct[5]=1 → EXECI; Op=10 → BRANCH; Op=11 → FETCH.
  - MEMADR: Funct[0]=1 → MEMRD, otherwise → MEMWR.
  - MEMRD → MEMWB → FETCH. MEMWR → FETCH.
  - EXECR and EXECI → ALUWB → FETCH. BRANCH → FETCH.
- Per-state outputs. Any select not listed here is 0.
  - FETCH: AdrSrc 0, ALUSrcA 1, ALUSrcB 10, ResultSrc 10, IRWrite 1, PCWrite 1.
  - DECODE: ALUSrcA 1, ALUSrcB 10, ResultSrc 10.
  - MEMADR and EXECI: ALUSrcB 01.
  - MEMRD and MEMWR: AdrSrc 1. MEMWR also asserts MemW.
  - MEMWB: ResultSrc 01, RegW.
  - ALUWB: RegW.
  - BRANCH: ALUSrcB 01, ResultSrc 10, Branch.
- ALU decode applies only in EXECR and EXECI. Cmd = Funct[4:1]:
  - 0100 → ADD; 0010 → SUB; 0000 → AND; 1100 → ORR.
  - 1010 (CMP) → SUB with NoWrite = 1.
  - Any other value → ADD with no flag write.
  - In all other states ALUControl = 00.
- Flag write selector FlagW, valid in EXECR and EXECI only:
  - FlagW[1] (N,Z) = Funct[0].
  - FlagW[0] (C,V) = Funct[0] & (Cmd is ADD, SUB or CMP).
  - CMP always sets FlagW = 11.
- Condition check on Cond against the registered flags:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
  - AL (1110) = 1; 1111 = 0.
- CondEx is latched into condex_q at the DECODE edge. All later gating uses condex_q, so a flag update in EXEC cannot change the same instruction's writeback.
- Gated enables:
  - RegWrite = RegW & condex_q & ~NoWrite.
  - MemWrite = MemW & condex_q.
  - PCWrite = FETCH | (condex_q & (Branch | (RegW & Rd==1111))).
  - Flags[3:2] load when FlagW[1] & condex_q; Flags[1:0] load when FlagW[0] & condex_q.

## Timing
- Reset (reset=0, asynchronous):
  - State = FETCH, Flags = 0000, condex_q = 0.
  - While reset is low, PCWrite, IRWrite, RegWrite and MemWrite are forced to 0. Selects hold their FETCH values.
- Reset asserted mid-instruction aborts the instruction immediately. The first FETCH happens on the first edge after reset is released.
- All outputs are Moore outputs: a combinational function of State, Instr and registered flags only.
- Instruction latency, FETCH included: LDR 5 cycles; STR 4; data-processing 4; B 3; Op=11 2.
- Flags written in EXECR/EXECI are visible from the ALUWB cycle onward.

## Configuration
- MCCTRL_SKIP_FALSE_EN:
  - Defined: in DECODE, if the condition evaluates false, the next state is FETCH regardless of Op. Every failed instruction takes 2 cycles.
  - Undefined: a failed instruction follows its normal state path with all writes suppressed, so latency is unchanged.

## Test plan
- Reset held low for 3 cycles: State=0 and all four write enables 0. After release, IRWrite=PCWrite=1 on the first cycle.
- ADDS R1,R2,R3 (Cond=1110, Op=00, Funct=001001) with ALUFlags=0110:
  - States 0,1,6,8.
  - In EXECR, ALUControl=00 and Flags become 0110.
  - In ALUWB, RegWrite=1.
- With Z=1: CMP, then a BNE. The BNE takes states 0,1,9 with PCWrite=0 in BRANCH. With MCCTRL_SKIP_FALSE_EN defined, it takes states 0,1,0.
- LDR (Op=01, Funct[0]=1):
  - States 0,1,2,3,4.
  - AdrSrc=1 in MEMRD; ResultSrc=01 and RegWrite=1 in MEMWB.
- STR with Cond=0000 and Z=1: MemWrite=1 in MEMWR. The same STR with Z=0: MemWrite=0.
- CMP (Funct=010101) in EXECR: ALUControl=01, FlagW=11, and RegWrite=0 in ALUWB.

Source files
------------

// File: rtl/multicycle_control.sv
// Moore sequencer and instruction decoder for the multicycle ARM-subset datapath; holds NZCV and condition-gates all writes.
// Optional MCCTRL_SKIP_FALSE_EN: a condition-failed instruction returns to FETCH straight from DECODE.
module multicycle_control (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic        AdrSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ImmSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ALUControl,
    output logic [3:0]  State
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXECR  = 4'd6;
    localparam logic [3:0] S_EXECI  = 4'd7;
    localparam logic [3:0] S_ALUWB  = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;

    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] cmd;
    logic       unused_rn;

    assign cond      = Instr[19:16];
    assign op        = Instr[15:14];
    assign funct     = Instr[13:8];
    assign rd        = Instr[3:0];
    assign cmd       = funct[4:1];
    assign unused_rn = ^Instr[7:4];

    logic [3:0] state_q, state_d;
    logic [3:0] decode_next;
    logic [3:0] flags_q;
    logic       condex_q;
    logic       cond_ex;
    logic       flag_n, flag_z, flag_c, flag_v;

    assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'b0000: cond_ex = flag_z;
            4'b0001: cond_ex = !flag_z;
            4'b0010: cond_ex = flag_c;
            4'b0011: cond_ex = !flag_c;
            4'b0100: cond_ex = flag_n;
            4'b0101: cond_ex = !flag_n;
            4'b0110: cond_ex = flag_v;
            4'b0111: cond_ex = !flag_v;
            4'b1000: cond_ex = flag_c && !flag_z;
            4'b1001: cond_ex = !flag_c || flag_z;
            4'b1010: cond_ex = (flag_n == flag_v);
            4'b1011: cond_ex = (flag_n != flag_v);
            4'b1100: cond_ex = !flag_z && (flag_n == flag_v);
            4'b1101: cond_ex = flag_z || (flag_n != flag_v);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // Unrecognised commands behave as ADD but never touch the flags.
    logic [1:0] alu_dec;
    logic [1:0] flagw_dec;
    logic       no_write;

    always_comb begin
        alu_dec   = 2'b00;
        flagw_dec = 2'b00;
        case (cmd)
            4'b0100: begin alu_dec = 2'b00; flagw_dec = {funct[0], funct[0]}; end
            4'b0010: begin alu_dec = 2'b01; flagw_dec = {funct[0], funct[0]}; end
            4'b0000: begin alu_dec = 2'b10; flagw_dec = {funct[0], 1'b0};     end
            4'b1100: begin alu_dec = 2'b11; flagw_dec = {funct[0], 1'b0};     end
            4'b1010: begin alu_dec = 2'b01; flagw_dec = 2'b11;                end
            default: begin alu_dec = 2'b00; flagw_dec = 2'b00;                end
        endcase
    end

    assign no_write = (op == 2'b00) && (cmd == 4'b1010);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        decode_next = S_FETCH;
        case (op)
            2'b01:   decode_next = S_MEMADR;
            2'b00:   decode_next = funct[5] ? S_EXECI : S_EXECR;
            2'b10:   decode_next = S_BRANCH;
            default: decode_next = S_FETCH;
        endcase

        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
`ifdef MCCTRL_SKIP_FALSE_EN
            S_DECODE: state_d = cond_ex ? decode_next : S_FETCH;
`else
            S_DECODE: state_d = decode_next;
`endif
            S_MEMADR: state_d = funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXECR:  state_d = S_ALUWB;
            S_EXECI:  state_d = S_ALUWB;
            default:  state_d = S_FETCH;
        endcase
    end

    logic       is_fetch, ir_w, reg_w, mem_w, branch;
    logic [1:0] flag_w;

    always_comb begin
        is_fetch   = 1'b0;
        ir_w       = 1'b0;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        branch     = 1'b0;
        flag_w     = 2'b00;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = 2'b00;
        case (state_q)
            S_FETCH: begin
                is_fetch  = 1'b1;
                ir_w      = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_MEMADR: ALUSrcB = 2'b01;
            S_MEMRD:  AdrSrc  = 1'b1;
            S_MEMWR: begin
                AdrSrc = 1'b1;
                mem_w  = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                reg_w     = 1'b1;
            end
            S_EXECR: begin
                ALUControl = alu_dec;
                flag_w     = flagw_dec;
            end
            S_EXECI: begin
                ALUSrcB    = 2'b01;
                ALUControl = alu_dec;
                flag_w     = flagw_dec;
            end
            S_ALUWB: reg_w = 1'b1;
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                branch    = 1'b1;
            end
            default: ;
        endcase
    end

    // Writes are gated by the condition captured in DECODE, so EXEC flag updates cannot affect their own writeback.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_q  <= 4'b0000;
            condex_q <= 1'b0;
        end else begin
            if (state_q == S_DECODE) condex_q <= cond_ex;
            if (flag_w[1] && condex_q) flags_q[3:2] <= ALUFlags[3:2];
            if (flag_w[0] && condex_q) flags_q[1:0] <= ALUFlags[1:0];
        end
    end

    assign IRWrite  = reset && ir_w;
    assign RegWrite = reset && reg_w && condex_q && !no_write;
    assign MemWrite = reset && mem_w && condex_q;
    assign PCWrite  = reset && (is_fetch || (condex_q && (branch || (reg_w && (rd == 4'b1111)))));
    assign RegSrc   = {op == 2'b01, op == 2'b10};
    assign ImmSrc   = op;
    assign State    = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed scenarios plus a randomized instruction stream against an instruction-level model.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA;
    logic [1:0]  RegSrc, ImmSrc, ALUSrcB, ResultSrc, ALUControl;
    logic [3:0]  State;

    multicycle_control dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUControl(ALUControl), .State(State)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    logic [3:0] mflags;

    typedef struct packed {
        logic [3:0] st;
        logic [3:0] we;   // {PCWrite, IRWrite, RegWrite, MemWrite}
        logic [1:0] aluc;
        logic       adr;
        logic [1:0] res;
        logic [1:0] srcb;
    } obs_t;

    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Instruction-level reference: cycle count, state path, per-cycle write enables, ALU op, flag effect.
    task automatic model_instr(input logic [19:0] ins, input logic [3:0] alu, output int n, output int exi,
                               output logic [3:0] est [5], output logic [3:0] ewe [5], output logic [1:0] eal [5]);
        logic [3:0] c, cmd, rd;
        logic [1:0] op;
        logic [5:0] fn;
        logic ce;
        int last;
        c = ins[19:16]; op = ins[15:14]; fn = ins[13:8]; rd = ins[3:0]; cmd = fn[4:1];
        ce = cond_ok(c, mflags);
        exi = -1;
        for (int i = 0; i < 5; i++) begin est[i] = 4'd0; ewe[i] = 4'b0; eal[i] = 2'b0; end
        est[1] = 4'd1;
        ewe[0] = 4'b1100;
        case (op)
            2'b01: if (fn[0]) begin n = 5; est[2] = 4'd2; est[3] = 4'd3; est[4] = 4'd4; end
                   else       begin n = 4; est[2] = 4'd2; est[3] = 4'd5; end
            2'b00: begin n = 4; est[2] = fn[5] ? 4'd7 : 4'd6; est[3] = 4'd8; exi = 2; end
            2'b10: begin n = 3; est[2] = 4'd9; end
            default: n = 2;
        endcase
`ifdef MCCTRL_SKIP_FALSE_EN
        if (!ce) begin n = 2; exi = -1; end
`endif
        last = n - 1;
        if (ce && n > 2) begin
            case (op)
                2'b01: if (fn[0]) begin ewe[last][1] = 1'b1; if (rd == 4'hF) ewe[last][3] = 1'b1; end
                       else ewe[last][0] = 1'b1;
                2'b00: begin
                    if (cmd != 4'b1010) ewe[last][1] = 1'b1;
                    if (rd == 4'hF) ewe[last][3] = 1'b1;
                end
                2'b10: ewe[last][3] = 1'b1;
                default: ;
            endcase
        end
        if (exi == 2) begin
            case (cmd)
                4'b0010, 4'b1010: eal[2] = 2'b01;
                4'b0000:          eal[2] = 2'b10;
                4'b1100:          eal[2] = 2'b11;
                default:          eal[2] = 2'b00;
            endcase
            if (ce) begin
                if (cmd == 4'b1010 || (fn[0] && (cmd == 4'b0100 || cmd == 4'b0010))) mflags = alu;
                else if (fn[0] && (cmd == 4'b0000 || cmd == 4'b1100)) mflags[3:2] = alu[3:2];
            end
        end
    endtask

    task automatic run_instr(input logic [19:0] ins, input logic [3:0] alu, input int n, input int exi,
                             output obs_t o [5]);
        for (int i = 0; i < 5; i++) o[i] = '0;
        for (int i = 0; i < n; i++) begin
            Instr    = ins;
            ALUFlags = (i == exi) ? alu : 4'($urandom);
            #1;
            o[i] = '{st: State, we: {PCWrite, IRWrite, RegWrite, MemWrite}, aluc: ALUControl,
                     adr: AdrSrc, res: ResultSrc, srcb: ALUSrcB};
            @(posedge clk); #1;
        end
    endtask

    task automatic do_instr(input logic [19:0] ins, input logic [3:0] alu, output obs_t o [5], output int n);
        int exi;
        logic [3:0] est [5];
        logic [3:0] ewe [5];
        logic [1:0] eal [5];
        model_instr(ins, alu, n, exi, est, ewe, eal);
        run_instr(ins, alu, n, exi, o);
    endtask

    localparam logic [19:0] I_ADDS = {4'hE, 2'b00, 6'b001001, 4'h2, 4'h1};
    localparam logic [19:0] I_CMP  = {4'hE, 2'b00, 6'b010101, 4'h1, 4'h0};
    localparam logic [19:0] I_LDR  = {4'hE, 2'b01, 6'b011001, 4'h0, 4'h3};
    localparam logic [19:0] I_STR0 = {4'h0, 2'b01, 6'b011000, 4'h0, 4'h2};

    function automatic logic [19:0] br(input logic [3:0] c);
        return {c, 2'b10, 6'b101000, 8'h00};
    endfunction

    task automatic test_reset();
        reset = 1'b0; Instr = '0; ALUFlags = '0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++; if (State !== 4'd0) $display("FAIL reset_state cyc%0d: got %0d want 0", i, State); else passes++;
            checks++; if ({PCWrite, IRWrite, RegWrite, MemWrite} !== 4'b0000)
                $display("FAIL reset_we cyc%0d: got %b want 0000", i, {PCWrite, IRWrite, RegWrite, MemWrite}); else passes++;
        end
        checks++; if (ALUSrcB !== 2'b10) $display("FAIL reset_srcb: got %b want 10", ALUSrcB); else passes++;
        reset = 1'b1; #1;
        checks++; if ({PCWrite, IRWrite} !== 2'b11) $display("FAIL release_fetch: got %b want 11", {PCWrite, IRWrite}); else passes++;
        mflags = 4'b0000;
    endtask

    task automatic test_adds();
        obs_t o [5];
        int n;
        logic [3:0] path [4] = '{4'd0, 4'd1, 4'd6, 4'd8};
        do_instr(I_ADDS, 4'b0110, o, n);
        for (int i = 0; i < 4; i++) begin
            checks++; if (o[i].st !== path[i]) $display("FAIL adds_path[%0d]: got %0d want %0d", i, o[i].st, path[i]); else passes++;
        end
        checks++; if (o[2].aluc !== 2'b00) $display("FAIL adds_aluc: got %b want 00", o[2].aluc); else passes++;
        checks++; if (o[3].we[1] !== 1'b1) $display("FAIL adds_regwrite: got %b want 1", o[3].we[1]); else passes++;
        // Flags now 0110: EQ and CS taken
        do_instr(br(4'h0), 4'h0, o, n);
        checks++; if (o[2].st !== 4'd9 || o[2].we[3] !== 1'b1) $display("FAIL adds_beq: got st%0d pc%b want st9 pc1", o[2].st, o[2].we[3]); else passes++;
        do_instr(br(4'h2), 4'h0, o, n);
        checks++; if (o[2].st !== 4'd9 || o[2].we[3] !== 1'b1) $display("FAIL adds_bcs: got st%0d pc%b want st9 pc1", o[2].st, o[2].we[3]); else passes++;
    endtask

    task automatic test_cmp_bne();
        obs_t o [5];
        int n;
        do_instr(I_CMP, 4'b0100, o, n);
        checks++; if (o[2].st !== 4'd6 || o[2].aluc !== 2'b01) $display("FAIL cmp_exec: got st%0d aluc%b want st6 aluc01", o[2].st, o[2].aluc); else passes++;
        checks++; if (o[3].st !== 4'd8 || o[3].we[1] !== 1'b0) $display("FAIL cmp_nowrite: got st%0d rw%b want st8 rw0", o[3].st, o[3].we[1]); else passes++;
        do_instr(br(4'h1), 4'h0, o, n);
        checks++; if (o[1].st !== 4'd1) $display("FAIL bne_decode: got %0d want 1", o[1].st); else passes++;
`ifdef MCCTRL_SKIP_FALSE_EN
        checks++; if (State !== 4'd0) $display("FAIL bne_skip: got %0d want 0", State); else passes++;
`else
        checks++; if (o[2].st !== 4'd9 || o[2].we[3] !== 1'b0) $display("FAIL bne_branch: got st%0d pc%b want st9 pc0", o[2].st, o[2].we[3]); else passes++;
`endif
    endtask

    task automatic test_ldr();
        obs_t o [5];
        int n;
        do_instr(I_LDR, 4'($urandom), o, n);
        for (int i = 0; i < 5; i++) begin
            checks++; if (o[i].st !== 4'(i)) $display("FAIL ldr_path[%0d]: got %0d want %0d", i, o[i].st, i); else passes++;
        end
        checks++; if (o[3].adr !== 1'b1) $display("FAIL ldr_adrsrc: got %b want 1", o[3].adr); else passes++;
        checks++; if (o[4].res !== 2'b01 || o[4].we[1] !== 1'b1) $display("FAIL ldr_wb: got res%b rw%b want res01 rw1", o[4].res, o[4].we[1]); else passes++;
    endtask

    task automatic test_str_cond();
        obs_t o [5];
        int n;
        do_instr(I_CMP, 4'b0100, o, n);
        do_instr(I_STR0, 4'h0, o, n);
        checks++; if (o[3].st !== 4'd5 || o[3].we[0] !== 1'b1) $display("FAIL streq_z1: got st%0d mw%b want st5 mw1", o[3].st, o[3].we[0]); else passes++;
        do_instr(I_CMP, 4'b0000, o, n);
        do_instr(I_STR0, 4'h0, o, n);
`ifdef MCCTRL_SKIP_FALSE_EN
        checks++; if (State !== 4'd0 || o[1].we[0] !== 1'b0) $display("FAIL streq_z0_skip: got st%0d mw%b want st0 mw0", State, o[1].we[0]); else passes++;
`else
        checks++; if (o[3].st !== 4'd5 || o[3].we[0] !== 1'b0) $display("FAIL streq_z0: got st%0d mw%b want st5 mw0", o[3].st, o[3].we[0]); else passes++;
`endif
    endtask

    task automatic test_cmp_flags();
        obs_t o [5];
        int n;
        do_instr(I_CMP, 4'b1001, o, n);
        do_instr(br(4'hA), 4'h0, o, n);
        checks++; if (o[2].st !== 4'd9 || o[2].we[3] !== 1'b1) $display("FAIL cmp_bge: got st%0d pc%b want st9 pc1", o[2].st, o[2].we[3]); else passes++;
        do_instr(br(4'h2), 4'h0, o, n);
`ifdef MCCTRL_SKIP_FALSE_EN
        checks++; if (State !== 4'd0) $display("FAIL cmp_bcs_skip: got %0d want 0", State); else passes++;
`else
        checks++; if (o[2].we[3] !== 1'b0) $display("FAIL cmp_bcs: got pc%b want pc0", o[2].we[3]); else passes++;
`endif
    endtask

    task automatic test_midreset();
        obs_t o [5];
        int n, exi;
        logic [3:0] est [5];
        logic [3:0] ewe [5];
        logic [1:0] eal [5];
        model_instr(I_LDR, 4'h0, n, exi, est, ewe, eal);
        run_instr(I_LDR, 4'h0, 3, -1, o);
        reset = 1'b0; #1;
        checks++; if (State !== 4'd0) $display("FAIL midreset_async: got %0d want 0", State); else passes++;
        checks++; if ({PCWrite, IRWrite, RegWrite, MemWrite} !== 4'b0000)
            $display("FAIL midreset_we: got %b want 0000", {PCWrite, IRWrite, RegWrite, MemWrite}); else passes++;
        @(posedge clk); #1;
        reset = 1'b1; #1;
        checks++; if (State !== 4'd0 || {PCWrite, IRWrite} !== 2'b11) $display("FAIL midreset_release: got st%0d %b want st0 11", State, {PCWrite, IRWrite}); else passes++;
        mflags = 4'b0000;
    endtask

    task automatic test_random();
        logic [3:0] cmds [5] = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010};
        for (int k = 0; k < 300; k++) begin
            logic [3:0] c, cmd, rd, alu;
            logic [1:0] op;
            logic [19:0] ins;
            int n, exi;
            logic [3:0] est [5];
            logic [3:0] ewe [5];
            logic [1:0] eal [5];
            obs_t o [5];
            c   = ($urandom_range(0, 3) == 0) ? 4'hE : 4'($urandom);
            op  = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
            cmd = ($urandom_range(0, 4) == 0) ? 4'($urandom) : cmds[$urandom_range(0, 4)];
            rd  = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom);
            alu = 4'($urandom);
            ins = {c, op, 1'($urandom), cmd, 1'($urandom), 4'($urandom), rd};
            model_instr(ins, alu, n, exi, est, ewe, eal);
            run_instr(ins, alu, n, exi, o);
            for (int i = 0; i < n; i++) begin
                checks++; if (o[i].st !== est[i]) $display("FAIL rnd%0d_state[%0d] ins=%h: got %0d want %0d", k, i, ins, o[i].st, est[i]); else passes++;
                checks++; if (o[i].we !== ewe[i]) $display("FAIL rnd%0d_we[%0d] ins=%h: got %b want %b", k, i, ins, o[i].we, ewe[i]); else passes++;
                checks++; if (o[i].aluc !== eal[i]) $display("FAIL rnd%0d_aluc[%0d] ins=%h: got %b want %b", k, i, ins, o[i].aluc, eal[i]); else passes++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_adds();
        test_cmp_bne();
        test_ldr();
        test_str_cond();
        test_cmp_flags();
        test_midreset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
